muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Command sequencer sitting directly upstream of `mul_divider` on a private register bus. It accepts queued multiply/divide commands over a valid/ready interface and loads the operands into `mul_divider` with write strobes. It then starts the engine, waits for `muldiv_int`, captures the result and returns it in order on a buffered valid/ready response interface. Divide-by-zero and engine timeouts are reported per response.

## Interface
Parameters:
- `CMD_DEPTH`, 4: command FIFO entries (power of 2, ≥2).
- `RSP_DEPTH`, 2: response FIFO entries (power of 2, ≥2).
- `TIMEOUT`, 32: cycles allowed in WAIT before an abort.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset. `mul_divider` reset is driven from `~rst`.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command FIFO not full.
- `cmd_op`  in  1  0 = multiply, 1 = divide.
- `cmd_a`  in  16  multiply: `a[7:0]` is the multiplicand. Divide: 16-bit dividend.
- `cmd_b`  in  8  multiplier or divisor.
- `rsp_valid`  out  1  response FIFO not empty.
- `rsp_ready`  in  1  response consumed.
- `rsp_res`  out  16  product or quotient.
- `rsp_rem`  out  8  remainder (0 for multiply).
- `rsp_err`  out  1  divide-by-zero or timeout.
- `busy`  out  1  state ≠ IDLE.
- `dbus_wdata`  out  8  write data to `mul_divider`.
- `muldiv_cn_wctrl`, `muldiv_ar_wctrl`, `muldiv_br_wctrl`, `muldiv_hr_wctrl`  out  1 each  one-cycle write strobes.
- `muldiv_int`  in  1  engine done flag.
- `muldiv_br`, `muldiv_hr`, `muldiv_cr`  in  8 each  engine result registers.

## Operation
- Commands are pushed into the command FIFO on `cmd_valid & cmd_ready`.
- Responses are popped from the response FIFO on `rsp_valid & rsp_ready`.
- IDLE: if the command FIFO is non-empty and the response FIFO is not full, pop one command.
  - Divide with `b == 0`: push {res=16'hFFFF, rem=0, err=1}, stay in IDLE, issue no strobes.
  - Otherwise latch the command and go to LD_AR.
- LD_AR: `ar_wctrl`, data = `b`.
- LD_BR: `br_wctrl`, data = `a[7:0]`.
- LD_HR: `hr_wctrl`, data = `a[15:8]` for divide, 8'h00 for multiply.
- START: `cn_wctrl`, data = 8'h20 (multiply) or 8'h28 (divide). This writes run=1, md, sm=0, f=0 and clears cr.
- WAIT: timer increments each cycle.
  - On `muldiv_int == 1` in a cycle, sample the result registers that same cycle:
    - multiply: res = {hr, cr}, rem = 0;
    - divide: res = {hr, br}, rem = cr.
  - In that same cycle, push {res, rem, err=0}, drive `cn_wctrl` with data 8'h00 to clear f and run, then go to IDLE.
  - If the timer reaches `TIMEOUT` with no interrupt: drive `cn_wctrl` with 8'h00, push {0, 0, err=1}, go to IDLE.
- At most one command is in flight. The space check in IDLE guarantees that the push in WAIT never finds the response FIFO full.
- Responses are returned strictly in command order.
- Only one strobe is active in any cycle. `dbus_wdata` is 8'h00 whenever no strobe is active.

## Timing
- Reset values: `cmd_ready=1`, `rsp_valid=0`, `rsp_res=0`, `rsp_rem=0`, `rsp_err=0`, `busy=0`, all strobes 0, `dbus_wdata=0`.
- Both FIFOs are emptied and the state returns to IDLE.
- A reset in any state, including WAIT, aborts the operation with no response. The engine is reset alongside.
- A command accepted in cycle c is popped at c+1 (p). From there:
  - LD_AR at p+1, LD_BR at p+2, LD_HR at p+3, START at p+4.
  - `muldiv_int` rises at p+13 (multiply) or p+21 (divide), when the capture and push happen.
  - `rsp_valid` rises at c+15 (multiply) or c+23 (divide).
- Divide-by-zero: `rsp_valid` rises at c+2.
- `cmd_ready` depends on FIFO fill level only. It does not account for a pop in the same cycle.
- Simultaneous push and pop on either FIFO are legal and leave the count unchanged. FIFO pointers wrap modulo the depth.

## Structure
- Shared package `muldiv_seq_pkg`:
  - state enum (IDLE, LD_AR, LD_BR, LD_HR, START, WAIT);
  - constants `CN_MUL_START=8'h20`, `CN_DIV_START=8'h28`, `CN_CLEAR=8'h00`;
  - `OP_MUL=0`, `OP_DIV=1`;
  - command and response packed structs.
- Sub-module `sync_fifo` (parameterised width and depth, synchronous active-high reset) is instantiated twice: 25-bit commands and 25-bit responses.

## Test plan
- Multiply a=16'h00C8, b=8'h64, with a real `mul_divider` attached → res=16'h4E20, rem=0, err=0. Strobe order is ar, br, hr, cn(20), cn(00). `rsp_valid` rises at c+15.
- Divide a=16'hFFFF, b=8'h10 → res=16'h0FFF, rem=8'h0F, err=0. `rsp_valid` rises at c+23.
- Divide with b=0 → res=16'hFFFF, rem=0, err=1, no strobes. `rsp_valid` rises at c+2.
- Send 7 back-to-back commands with `rsp_ready=0`:
  - two responses complete and fill the response FIFO;
  - four commands are held in the command FIFO;
  - `cmd_ready` drops while the 7th command is offered.
  - After `rsp_ready=1`, all 7 responses come out in order with correct values.
- Tie `muldiv_int` low → after START plus 32 cycles, `cn_wctrl` fires with 8'h00 and the response is {0, 0, err=1}.
- Assert `rst` during WAIT of a divide → all outputs return to reset values and no response appears. The next multiply, 3×5, returns 16'h000F.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared states, control words and FIFO record layouts for the muldiv sequencer
package muldiv_seq_pkg;

    typedef enum logic [2:0] {IDLE, LD_AR, LD_BR, LD_HR, START, WAIT} state_e;

    localparam logic [7:0] CN_MUL_START = 8'h20;
    localparam logic [7:0] CN_DIV_START = 8'h28;
    localparam logic [7:0] CN_CLEAR     = 8'h00;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef struct packed {
        logic        op;
        logic [15:0] a;
        logic [7:0]  b;
    } cmd_t;

    typedef struct packed {
        logic [15:0] res;
        logic [7:0]  rem;
        logic        err;
    } rsp_t;

endpackage

// File: rtl/muldiv_seq_fifo.sv
// sync_fifo: single-clock FIFO; read data reads as zero while empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_q + AW'(do_push);
            rptr_q <= rptr_q + AW'(do_pop);
            cnt_q  <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem_q[wptr_q] <= wdata_i;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: queues mul/div commands, drives mul_divider register writes and
// returns results (or div-by-zero / timeout errors) in command order
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 2,
    parameter int TIMEOUT   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_res,
    output logic [7:0]  rsp_rem,
    output logic        rsp_err,
    output logic        busy,
    output logic [7:0]  dbus_wdata,
    output logic        muldiv_cn_wctrl,
    output logic        muldiv_ar_wctrl,
    output logic        muldiv_br_wctrl,
    output logic        muldiv_hr_wctrl,
    input  logic        muldiv_int,
    input  logic [7:0]  muldiv_br,
    input  logic [7:0]  muldiv_hr,
    input  logic [7:0]  muldiv_cr
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    cmd_t          cmd_q, cmd_d, cmd_in, cmd_head;
    rsp_t          rsp_wr, rsp_head;
    logic [TW-1:0] timer_q, timer_d;
    logic          cmd_full, cmd_empty, cmd_pop;
    logic          rsp_full, rsp_empty, rsp_push;
    logic          is_div;

    assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b};
    assign cmd_ready = ~cmd_full;
    assign rsp_valid = ~rsp_empty;
    assign rsp_res   = rsp_head.res;
    assign rsp_rem   = rsp_head.rem;
    assign rsp_err   = rsp_head.err;
    assign busy      = state_q != IDLE;
    assign is_div    = cmd_q.op == OP_DIV;

    sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .wdata_i (cmd_in),
        .pop_i   (cmd_pop),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .rdata_o (cmd_head)
    );

    sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rsp_push),
        .wdata_i (rsp_wr),
        .pop_i   (rsp_ready),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .rdata_o (rsp_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        timer_d         = timer_q;
        cmd_pop         = 1'b0;
        rsp_push        = 1'b0;
        rsp_wr          = '0;
        dbus_wdata      = 8'h00;
        muldiv_cn_wctrl = 1'b0;
        muldiv_ar_wctrl = 1'b0;
        muldiv_br_wctrl = 1'b0;
        muldiv_hr_wctrl = 1'b0;
        case (state_q)
            IDLE: begin
                // Popping only with response space free keeps the later WAIT push safe
                if (!cmd_empty && !rsp_full) begin
                    cmd_pop = 1'b1;
                    if (cmd_head.op == OP_DIV && cmd_head.b == 8'h00) begin
                        rsp_push = 1'b1;
                        rsp_wr   = '{res: 16'hFFFF, rem: 8'h00, err: 1'b1};
                    end else begin
                        cmd_d   = cmd_head;
                        state_d = LD_AR;
                    end
                end
            end
            LD_AR: begin
                muldiv_ar_wctrl = 1'b1;
                dbus_wdata      = cmd_q.b;
                state_d         = LD_BR;
            end
            LD_BR: begin
                muldiv_br_wctrl = 1'b1;
                dbus_wdata      = cmd_q.a[7:0];
                state_d         = LD_HR;
            end
            LD_HR: begin
                muldiv_hr_wctrl = 1'b1;
                dbus_wdata      = is_div ? cmd_q.a[15:8] : 8'h00;
                state_d         = START;
            end
            START: begin
                muldiv_cn_wctrl = 1'b1;
                dbus_wdata      = is_div ? CN_DIV_START : CN_MUL_START;
                timer_d         = '0;
                state_d         = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 1'b1;
                if (muldiv_int) begin
                    muldiv_cn_wctrl = 1'b1;
                    rsp_push        = 1'b1;
                    rsp_wr          = '{res: is_div ? {muldiv_hr, muldiv_br} : {muldiv_hr, muldiv_cr},
                                        rem: is_div ? muldiv_cr : 8'h00, err: 1'b0};
                    state_d         = IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    muldiv_cn_wctrl = 1'b1;
                    rsp_push        = 1'b1;
                    rsp_wr          = '{res: 16'h0000, rem: 8'h00, err: 1'b1};
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors against muldiv_seq with a behavioural mul_divider engine
`timescale 1ns/1ps
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, cmd_op, rsp_valid, rsp_ready, rsp_err, busy;
    logic [15:0] cmd_a, rsp_res;
    logic [7:0]  cmd_b, rsp_rem, dbus_wdata;
    logic        cn_w, ar_w, br_w, hr_w, e_int;
    logic [7:0]  e_ar, e_br, e_hr, e_cr;
    logic        e_md, e_run, eng_dis;
    int          e_cnt;
    int          cyc = 0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_seq #(.CMD_DEPTH(4), .RSP_DEPTH(2), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
        .busy(busy), .dbus_wdata(dbus_wdata),
        .muldiv_cn_wctrl(cn_w), .muldiv_ar_wctrl(ar_w), .muldiv_br_wctrl(br_w), .muldiv_hr_wctrl(hr_w),
        .muldiv_int(e_int), .muldiv_br(e_br), .muldiv_hr(e_hr), .muldiv_cr(e_cr)
    );

    // Engine model: int appears 9 (mul) or 17 (div) cycles after the start write
    logic [15:0] prod, dq, dr;
    assign prod = {8'h00, e_br} * {8'h00, e_ar};
    assign dq   = (e_ar == 0) ? 16'h0 : {e_hr, e_br} / {8'h00, e_ar};
    assign dr   = (e_ar == 0) ? 16'h0 : {e_hr, e_br} % {8'h00, e_ar};

    always @(posedge clk) begin
        if (rst) begin
            e_ar <= 0; e_br <= 0; e_hr <= 0; e_cr <= 0;
            e_md <= 0; e_run <= 0; e_int <= 0; e_cnt <= 0;
        end else begin
            if (ar_w) e_ar <= dbus_wdata;
            if (br_w) e_br <= dbus_wdata;
            if (hr_w) e_hr <= dbus_wdata;
            if (cn_w) begin
                e_run <= dbus_wdata[5];
                e_md  <= dbus_wdata[3];
                e_int <= 1'b0;
                e_cnt <= dbus_wdata[3] ? 16 : 8;
                if (dbus_wdata[5]) e_cr <= 8'h00;
            end else if (e_run && !eng_dis && !e_int) begin
                e_cnt <= e_cnt - 1;
                if (e_cnt == 1) begin
                    e_int <= 1'b1;
                    if (e_md) begin
                        e_hr <= dq[15:8]; e_br <= dq[7:0]; e_cr <= dr[7:0];
                    end else begin
                        e_hr <= prod[15:8]; e_cr <= prod[7:0];
                    end
                end
            end
        end
    end

    typedef struct packed {
        logic [3:0]  s;
        logic [7:0]  d;
        logic [31:0] cyc;
    } ent_t;
    ent_t log_q[$];
    logic [3:0] strb;
    assign strb = {cn_w, ar_w, br_w, hr_w};

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(strb) > 1 || (strb == 4'b0 && dbus_wdata != 8'h00)) begin
                errors++;
                $display("FAIL strobe_exclusive: strobes=%b data=%h at cycle %0d", strb, dbus_wdata, cyc);
            end
            if (strb != 4'b0) log_q.push_back('{strb, dbus_wdata, 32'(cyc)});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic op, input logic [15:0] a, input logic [7:0] b, output int c_acc);
        bit ok = 0;
        c_acc = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = cmd_ready;
            @(negedge clk);
            if (ok) c_acc = cyc;
        end
        cmd_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic get(output logic [24:0] r, output int at, output bit got);
        got = 0; at = 0; r = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (rsp_valid) begin
                got = 1; at = cyc; r = {rsp_res, rsp_rem, rsp_err};
            end
            @(negedge clk);
        end
        if (!got) chk("rsp_timeout", 32'(got), 32'd1);
    endtask

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] res;
        logic [7:0]  rem;
        logic        err;
        int          lat;
    } vec_t;
    vec_t vt[8];

    initial begin
        int          c, at, n;
        bit          got, acc7, seen;
        logic [24:0] r;
        logic [15:0] ba[7];
        logic [7:0]  bb[7];
        logic [15:0] bexp;

        rst = 1; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 0; eng_dis = 0;
        vt[0] = '{1'b0, 16'h00C8, 8'h64, 16'h4E20, 8'h00, 1'b0, 15};
        vt[1] = '{1'b1, 16'hFFFF, 8'h10, 16'h0FFF, 8'h0F, 1'b0, 23};
        vt[2] = '{1'b1, 16'h1234, 8'h00, 16'hFFFF, 8'h00, 1'b1, 2};
        vt[3] = '{1'b0, 16'h00FF, 8'hFF, 16'hFE01, 8'h00, 1'b0, 15};
        vt[4] = '{1'b1, 16'h1234, 8'h07, 16'h0299, 8'h05, 1'b0, 23};
        vt[5] = '{1'b0, 16'hAB12, 8'h02, 16'h0024, 8'h00, 1'b0, 15};
        vt[6] = '{1'b1, 16'h00FF, 8'hFF, 16'h0001, 8'h00, 1'b0, 23};
        vt[7] = '{1'b0, 16'h0003, 8'h05, 16'h000F, 8'h00, 1'b0, 15};

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp", 32'({rsp_res, rsp_rem, rsp_err}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", 32'({strb, dbus_wdata}), 32'd0);
        rst = 0; rsp_ready = 1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            log_q.delete();
            send(vt[i].op, vt[i].a, vt[i].b, c);
            get(r, at, got);
            repeat (3) @(negedge clk);
            if (got) begin
                chk($sformatf("v%0d_res", i), 32'(r[24:9]), 32'(vt[i].res));
                chk($sformatf("v%0d_rem", i), 32'(r[8:1]), 32'(vt[i].rem));
                chk($sformatf("v%0d_err", i), 32'(r[0]), 32'(vt[i].err));
                chk($sformatf("v%0d_latency", i), 32'(at - c + 1), 32'(vt[i].lat));
            end
            if (vt[i].err) chk($sformatf("v%0d_no_strobes", i), 32'(log_q.size()), 32'd0);
            else begin
                chk($sformatf("v%0d_strobe_count", i), 32'(log_q.size()), 32'd5);
                if (log_q.size() == 5) begin
                    chk($sformatf("v%0d_ar", i), 32'({log_q[0].s, log_q[0].d}), 32'({4'b0100, vt[i].b}));
                    chk($sformatf("v%0d_br", i), 32'({log_q[1].s, log_q[1].d}), 32'({4'b0010, vt[i].a[7:0]}));
                    chk($sformatf("v%0d_hr", i), 32'({log_q[2].s, log_q[2].d}),
                        32'({4'b0001, vt[i].op ? vt[i].a[15:8] : 8'h00}));
                    chk($sformatf("v%0d_cn_start", i), 32'({log_q[3].s, log_q[3].d}),
                        32'({4'b1000, vt[i].op ? 8'h28 : 8'h20}));
                    chk($sformatf("v%0d_cn_clear", i), 32'({log_q[4].s, log_q[4].d}), 32'({4'b1000, 8'h00}));
                    chk($sformatf("v%0d_ar_cycle", i), log_q[0].cyc - 32'(c), 32'd1);
                    chk($sformatf("v%0d_run_cycles", i), log_q[4].cyc - log_q[3].cyc, vt[i].op ? 32'd17 : 32'd9);
                end
            end
        end

        // Timeout: engine never raises int
        eng_dis = 1; log_q.delete();
        send(1'b0, 16'h0005, 8'h06, c);
        get(r, at, got);
        repeat (2) @(negedge clk);
        if (got) chk("to_rsp", 32'(r), 32'h1);
        chk("to_strobe_count", 32'(log_q.size()), 32'd5);
        if (log_q.size() == 5) begin
            chk("to_cn_clear", 32'({log_q[4].s, log_q[4].d}), 32'({4'b1000, 8'h00}));
            chk("to_wait_cycles", log_q[4].cyc - log_q[3].cyc, 32'd32);
        end
        eng_dis = 0;

        // Reset in the middle of a divide's WAIT
        send(1'b1, 16'hFFFF, 8'h10, c);
        repeat (10) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1;
        @(negedge clk);
        chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_rsp", 32'({rsp_res, rsp_rem, rsp_err}), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_strobes", 32'({strb, dbus_wdata}), 32'd0);
        rst = 0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("mr_no_response", 32'(seen), 32'd0);
        send(1'b0, 16'h0003, 8'h05, c);
        get(r, at, got);
        if (got) chk("mr_next_mul", 32'(r), 32'({16'h000F, 8'h00, 1'b0}));

        // Back-to-back with the response side stalled
        for (int i = 0; i < 7; i++) begin
            ba[i] = 16'(i * 37 + 2);
            bb[i] = 8'(i * 11 + 7);
        end
        rsp_ready = 0;
        for (int i = 0; i < 6; i++) send(1'b0, ba[i], bb[i], c);
        cmd_valid = 1; cmd_op = 1'b0; cmd_a = ba[6]; cmd_b = bb[6];
        repeat (40) @(negedge clk);
        chk("b2b_cmd_ready_low", 32'(cmd_ready), 32'd0);
        chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_idle_stalled", 32'(busy), 32'd0);
        rsp_ready = 1; n = 0; acc7 = 0;
        for (int i = 0; i < 400 && n < 7; i++) begin
            if (cmd_valid && cmd_ready) acc7 = 1;
            if (rsp_valid) begin
                bexp = {8'h00, ba[n][7:0]} * {8'h00, bb[n]};
                chk($sformatf("b2b_rsp%0d", n), 32'({rsp_res, rsp_rem, rsp_err}), 32'({bexp, 8'h00, 1'b0}));
                n++;
            end
            @(negedge clk);
            if (acc7) cmd_valid = 0;
        end
        chk("b2b_7th_accepted", 32'(acc7), 32'd1);
        chk("b2b_count", 32'(n), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
